// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative 32-step multiply/divide unit with architectural
// HI/LO registers. MULT/MULTU use shift-add and DIV/DIVU use restoring
// division, both on operand magnitudes, with the sign fixed up in the
// final cycle. Optional feature macro: MULDIV_DIVZERO_EN. When it is
// defined, a divide by zero finishes early, leaves HI/LO unchanged and
// raises divz on its done pulse.
module muldiv_hilo (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
`ifdef MULDIV_DIVZERO_EN
    output logic        divz,
`endif
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // quotient/product must be negated
    logic        neg_rem_q, neg_rem_d;   // remainder must be negated
    logic [63:0] opa_q, opa_d;           // multiplicand, shifted left each step
    logic [31:0] opb_q, opb_d;           // multiplier (shifted right) or divisor
    logic [63:0] acc_q, acc_d;           // product, or dividend/quotient in [31:0]
    logic [31:0] rem_q, rem_d;           // partial remainder
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
    logic        dz_q, dz_d;             // accepted op is a divide by zero
    logic        divz_q, divz_d;
    logic        div_zero_in;
`endif

    logic        signed_op;
    logic        is_div_in;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic        q_bit;

    // Operand decode: magnitudes and sign flags of the incoming operands.
    always_comb begin
        signed_op = ~op[0];
        is_div_in = op[1];
        a_neg     = signed_op & SrcA[31];
        b_neg     = signed_op & SrcB[31];
        a_mag     = a_neg ? (~SrcA + 32'd1) : SrcA;
        b_mag     = b_neg ? (~SrcB + 32'd1) : SrcB;
`ifdef MULDIV_DIVZERO_EN
        div_zero_in = is_div_in && (SrcB == 32'd0);
`endif
    end

    // Control state register and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            divz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIVZERO_EN
            divz_q  <= divz_d;
`endif
        end
    end

    // Datapath registers.
    // NOTE: these are deliberately left without reset; every one is loaded on
    // the IDLE->RUN/FIN transition before it is read, so reset buys nothing.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        acc_q     <= acc_d;
        rem_q     <= rem_d;
`ifdef MULDIV_DIVZERO_EN
        dz_q      <= dz_d;
`endif
    end

    // Next-state logic: IDLE -> RUN (32 steps) -> FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_DIVZERO_EN
                    state_d = div_zero_in ? S_FIN : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN:   if (cnt_q == 6'd31) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand latch, one shift-add / restoring step per cycle,
    // sign fixup and HI/LO commit, plus mthi/mtlo writes while idle.
    always_comb begin
        // NOTE: every variable gets a hold/default value first so that no
        // path through the case statement leaves one unassigned (no latches).
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, acc_q[31]};
        q_bit     = 1'b0;
`ifdef MULDIV_DIVZERO_EN
        dz_d      = dz_q;
        divz_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Register writes land before a result that a same-cycle
                // start will later commit over them.
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    cnt_d     = 6'd0;
                    is_div_d  = is_div_in;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    opa_d     = {32'd0, a_mag};
                    opb_d     = b_mag;
                    acc_d     = is_div_in ? {32'd0, a_mag} : 64'd0;
                    rem_d     = 32'd0;
`ifdef MULDIV_DIVZERO_EN
                    dz_d      = div_zero_in;
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div_q) begin
                    // Shift the next dividend bit into the remainder and keep
                    // the trial subtraction only when it does not underflow.
                    q_bit = (rem_shift >= {1'b0, opb_q});
                    rem_d = q_bit ? (rem_shift[31:0] - opb_q) : rem_shift[31:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], q_bit};
                end else begin
                    if (opb_q[0]) acc_d = acc_q + opa_q;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
            end
            S_FIN: begin
                done_d = 1'b1;
`ifdef MULDIV_DIVZERO_EN
                divz_d = dz_q;
                if (!dz_q) begin
`else
                begin
`endif
                    if (is_div_q) begin
                        lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                        hi_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? (~acc_q + 64'd1) : acc_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        HI   = hi_q;
        LO   = lo_q;
`ifdef MULDIV_DIVZERO_EN
        divz = divz_q;
`endif
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed testbench for muldiv_hilo: latency, busy window, signed/unsigned
// results, busy-time guards, reset abort and divide by zero.
module tb_muldiv_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
`ifdef MULDIV_DIVZERO_EN
    logic        divz;
`endif
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_hilo dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
`ifdef MULDIV_DIVZERO_EN
        .divz  (divz),
`endif
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done after a start driven in the current cycle; lat is the
    // cycle offset of done from the start cycle, bcnt the busy cycles seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        do begin
            step();
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 60);
    endtask

    // Launch an op in the current cycle and check latency, busy window and result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_divz);
        int lat;
        int bcnt;
        start = 1'b1;
        op    = o;
        SrcA  = a;
        SrcB  = b;
        wait_done(lat, bcnt);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(exp_lat - 1));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " HI"}, 64'(HI), 64'(exp_hi));
        check({tag, " LO"}, 64'(LO), 64'(exp_lo));
`ifdef MULDIV_DIVZERO_EN
        check({tag, " divz"}, 64'(divz), 64'(exp_divz));
`else
        if (exp_divz) $display("note: divz expectation unused in this build");
`endif
    endtask

    initial begin
        int c;
        int dcount;
        int lat;
        int bcnt;

        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        SrcA  = 32'd0;
        SrcB  = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
`ifdef MULDIV_DIVZERO_EN
        check("reset divz", 64'(divz), 64'd0);
`endif

        // MULT -2 x 3 = -6.
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        step();
        check("done is a pulse", 64'(done), 64'd0);
        check("HI holds after done", 64'(HI), 64'hFFFF_FFFF);

        // Back-to-back ops: each next start is driven in the done cycle.
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m1sq", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
               32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h0000_0000, 32'h8000_0000, 1'b0);

        // Busy-time guards during DIVU 1000 / 7 = 142 r 6.
        step();
        start = 1'b1;
        op    = OP_DIVU;
        SrcA  = 32'd1000;
        SrcB  = 32'd7;
        c     = 0;
        do begin
            step();
            c++;
            start = 1'b0;
            hi_we = 1'b0;
            if (c == 5) begin
                start = 1'b1;
                op    = OP_MULT;
                SrcA  = 32'd3;
                SrcB  = 32'd4;
            end
            if (c == 10) begin
                hi_we = 1'b1;
                wdata = 32'h1234_5678;
            end
            if (c == 11) check("guard HI during busy", 64'(HI), 64'h0);
        end while (!done && c < 60);
        check("guard latency", 64'(c), 64'd34);
        check("guard LO", 64'(LO), 64'd142);
        check("guard HI", 64'(HI), 64'd6);
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        step();
        lo_we = 1'b0;
        check("mtlo LO", 64'(LO), 64'hCAFE_F00D);
        check("mtlo HI kept", 64'(HI), 64'd6);
        check("ignored start not queued", 64'(busy), 64'd0);

        // Reset aborts an in-flight MULT.
        start = 1'b1;
        op    = OP_MULT;
        SrcA  = 32'd9;
        SrcB  = 32'd9;
        for (int k = 1; k <= 15; k++) begin
            step();
            start = 1'b0;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort HI", 64'(HI), 64'd0);
        check("abort LO", 64'(LO), 64'd0);
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) dcount++;
            step();
        end
        check("abort no done pulse", 64'(dcount), 64'd0);
        run_op("mult_after_reset", OP_MULT, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0);

        // Divide by zero.
`ifdef MULDIV_DIVZERO_EN
        run_op("div5_0", OP_DIV, 32'd5, 32'd0, 2, 32'd0, 32'd42, 1'b1);
        run_op("divu_after_dz", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
`else
        run_op("div5_0", OP_DIV, 32'd5, 32'd0, 34, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("divu7_0", OP_DIVU, 32'd7, 32'd0, 34, 32'd7, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg7_0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 34,
               32'hFFFF_FFF9, 32'h0000_0001, 1'b0);
`endif

        // Same-cycle mthi with an accepted start: the result overwrites it.
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        start = 1'b1;
        op    = OP_MULTU;
        SrcA  = 32'd2;
        SrcB  = 32'd3;
        step();
        hi_we = 1'b0;
        start = 1'b0;
        check("same-cycle mthi visible", 64'(HI), 64'hDEAD_BEEF);
        wait_done(lat, bcnt);
        check("same-cycle latency", 64'(lat), 64'd33);
        check("same-cycle HI overwritten", 64'(HI), 64'd0);
        check("same-cycle LO", 64'(LO), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
